// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared types, default parameters and helpers for the RPSC fault sequencer
package rpsc_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        TRIPPED   = 2'd1,
        CLEARING  = 2'd2,
        LAMP_TEST = 2'd3
    } fault_seq_state_t;

    localparam int N_CH_DEF           = 8;
    localparam int DEBOUNCE_CYC_DEF   = 16;
    localparam int CLEAR_HOLD_CYC_DEF = 4;
    localparam int LAMP_TEST_CYC_DEF  = 1000;

    // Lowest set bit wins, so simultaneous faults resolve to the lowest channel.
    function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
        lowest_set_index = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set_index = 5'(i);
        end
    endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// rtl/rpsc_debounce.sv - single-channel 2-flop synchronizer plus stability counter
module rpsc_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // q follows s2 once s2 has disagreed with q for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                q   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rpsc_fault_sequencer.sv
// rtl/rpsc_fault_sequencer.sv - trip/acknowledge/clear and lamp-test sequencer; first-fault capture under RPSC_FIRST_FAULT_EN
module rpsc_fault_sequencer
    import rpsc_pkg::*;
#(
    parameter int N_CH           = N_CH_DEF,
    parameter int DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int CLEAR_HOLD_CYC = CLEAR_HOLD_CYC_DEF,
    parameter int LAMP_TEST_CYC  = LAMP_TEST_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         fault_in,
    input  logic                    clear_req,
    input  logic                    lamp_test_req,
    output logic [N_CH-1:0]         fault_q,
    output logic [N_CH-1:0]         fault_mem,
    output logic                    trip,
    output logic                    ff_clear,
    output logic                    la_test,
    output logic [$clog2(N_CH)-1:0] first_fault_id,
    output logic                    first_fault_valid,
    output logic                    clear_rejected
);

    localparam int IDW      = $clog2(N_CH);
    localparam int HOLD_MAX = (CLEAR_HOLD_CYC > LAMP_TEST_CYC) ? CLEAR_HOLD_CYC : LAMP_TEST_CYC;
    localparam int HW       = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] CLR_LAST = HW'(CLEAR_HOLD_CYC - 1);
    localparam logic [HW-1:0] LT_LAST  = HW'(LAMP_TEST_CYC - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_db
        rpsc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (fault_in[i]),
            .q     (fault_q[i])
        );
    end

    logic any_fault;
    assign any_fault = |fault_q;

    // Registered edge pulses: request edge to FSM action is two cycles.
    logic clr_prev, lt_prev, clr_edge, lt_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_prev <= 1'b0;
            lt_prev  <= 1'b0;
            clr_edge <= 1'b0;
            lt_edge  <= 1'b0;
        end else begin
            clr_prev <= clear_req;
            lt_prev  <= lamp_test_req;
            clr_edge <= clear_req & ~clr_prev;
            lt_edge  <= lamp_test_req & ~lt_prev;
        end
    end

    fault_seq_state_t state, state_nx;
    logic [HW-1:0]    hold_cnt;
    logic             lt_from_trip, lt_fault;

    always_comb begin
        state_nx       = state;
        clear_rejected = 1'b0;
        case (state)
            ARMED: begin
                if (any_fault)    state_nx = TRIPPED;
                else if (lt_edge) state_nx = LAMP_TEST;
            end
            TRIPPED: begin
                // A clear edge takes precedence; a coincident lamp-test edge is dropped.
                if (clr_edge) begin
                    if (!any_fault) state_nx = CLEARING;
                    else            clear_rejected = 1'b1;
                end else if (lt_edge) begin
                    state_nx = LAMP_TEST;
                end
            end
            CLEARING: begin
                if (hold_cnt == CLR_LAST) state_nx = ARMED;
            end
            LAMP_TEST: begin
                if (hold_cnt == LT_LAST)
                    state_nx = (lt_from_trip || lt_fault || any_fault) ? TRIPPED : ARMED;
            end
            default: state_nx = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARMED;
            hold_cnt     <= '0;
            lt_from_trip <= 1'b0;
            lt_fault     <= 1'b0;
            fault_mem    <= '0;
        end else begin
            state <= state_nx;
            if ((state_nx == state) && ((state == CLEARING) || (state == LAMP_TEST)))
                hold_cnt <= hold_cnt + HW'(1);
            else
                hold_cnt <= '0;
            if ((state != LAMP_TEST) && (state_nx == LAMP_TEST)) begin
                lt_from_trip <= (state == TRIPPED);
                lt_fault     <= 1'b0;
            end else if ((state == LAMP_TEST) && any_fault) begin
                lt_fault <= 1'b1;
            end
            fault_mem <= (state == CLEARING) ? '0 : (fault_mem | fault_q);
        end
    end

    assign trip     = (state == TRIPPED) || ((state == LAMP_TEST) && lt_from_trip);
    assign ff_clear = (state == CLEARING);
    assign la_test  = (state == LAMP_TEST);

`ifdef RPSC_FIRST_FAULT_EN
    logic [IDW-1:0] ff_id;
    logic           ff_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_id    <= '0;
            ff_valid <= 1'b0;
        end else if (state == CLEARING) begin
            ff_valid <= 1'b0;
        end else if (!ff_valid && any_fault) begin
            ff_valid <= 1'b1;
            ff_id    <= IDW'(lowest_set_index(32'(fault_q)));
        end
    end

    assign first_fault_id    = ff_id;
    assign first_fault_valid = ff_valid;
`else
    assign first_fault_id    = '0;
    assign first_fault_valid = 1'b0;
`endif

endmodule
